// File: rtl/uart_sched_pkg.sv
// Shared types and constants for the UART transmit scheduler.
// The CHK state exists only when UART_TX_CHECKSUM_EN is defined.
package uart_sched_pkg;

    localparam int unsigned MAX_REQ  = 8;
    localparam int unsigned IDX_W    = $clog2(MAX_REQ);
    localparam logic [7:0]  CHK_SEED = 8'h00;

`ifdef UART_TX_CHECKSUM_EN
    typedef enum logic [2:0] {StIdle, StLoad, StSend, StWait, StChk} tx_sched_state_t;
`else
    typedef enum logic [2:0] {StIdle, StLoad, StSend, StWait} tx_sched_state_t;
`endif

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// Requester and UART-side handshake bundle for uart_tx_scheduler.
// master: requesters plus UART; slave: the scheduler itself.
interface uart_tx_scheduler_if #(
    parameter int unsigned NUM_REQ = 2
);

    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 tx_start;
    logic [7:0]           tx_data;
    logic                 tx_done;
    logic [NUM_REQ-1:0]   grant;
    logic                 busy;

    modport master (
        output req_valid, req_data, req_last, tx_done,
        input  req_ready, tx_start, tx_data, grant, busy
    );

    modport slave (
        input  req_valid, req_data, req_last, tx_done,
        output req_ready, tx_start, tx_data, grant, busy
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request searching upward
// from last_grant+1, wrapping to the lowest index.
module rr_arbiter
    import uart_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [NUM_REQ-1:0] pick
);

    logic [NUM_REQ-1:0] pick_lo;
    logic [NUM_REQ-1:0] pick_hi;

    // Descending scan so the lowest qualifying index wins in each half.
    always_comb begin
        pick_lo = '0;
        pick_hi = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                pick_lo    = '0;
                pick_lo[i] = 1'b1;
            end
            if (req[i] && (i > int'(last_grant))) begin
                pick_hi    = '0;
                pick_hi[i] = 1'b1;
            end
        end
        pick = (|pick_hi) ? pick_hi : pick_lo;
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin packet scheduler feeding one UART transmitter byte by byte.
// Define UART_TX_CHECKSUM_EN to append an XOR checksum byte to every packet.
module uart_tx_scheduler
    import uart_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2
) (
    input logic                clock,
    input logic                reset,
    uart_tx_scheduler_if.slave bus
);

    tx_sched_state_t    state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]   last_grant_q, last_grant_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               last_flag_q, last_flag_d;
`ifdef UART_TX_CHECKSUM_EN
    logic [7:0]         chk_q, chk_d;
    // 0: checksum loaded, 1: start pulse, 2: wait for tx_done
    logic [1:0]         chk_phase_q, chk_phase_d;
`endif

    logic [NUM_REQ-1:0] pick;
    logic [IDX_W-1:0]   pick_idx;
    logic               own_valid;
    logic               own_last;
    logic [7:0]         own_data;

    rr_arbiter #(
        .NUM_REQ(NUM_REQ)
    ) u_arb (
        .req       (bus.req_valid),
        .last_grant(last_grant_q),
        .pick      (pick)
    );

    always_comb begin : owner_mux
        pick_idx  = '0;
        own_valid = 1'b0;
        own_last  = 1'b0;
        own_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick[i]) begin
                pick_idx = IDX_W'(i);
            end
            if (grant_q[i]) begin
                own_valid = bus.req_valid[i];
                own_last  = bus.req_last[i];
                own_data  = bus.req_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin : fsm_reg
        if (!reset) begin
            state_q      <= StIdle;
            grant_q      <= '0;
            last_grant_q <= IDX_W'(NUM_REQ - 1);
            tx_data_q    <= '0;
            last_flag_q  <= 1'b0;
`ifdef UART_TX_CHECKSUM_EN
            chk_q        <= CHK_SEED;
            chk_phase_q  <= 2'd0;
`endif
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            tx_data_q    <= tx_data_d;
            last_flag_q  <= last_flag_d;
`ifdef UART_TX_CHECKSUM_EN
            chk_q        <= chk_d;
            chk_phase_q  <= chk_phase_d;
`endif
        end
    end

    always_comb begin : fsm_next
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        tx_data_d    = tx_data_q;
        last_flag_d  = last_flag_q;
`ifdef UART_TX_CHECKSUM_EN
        chk_d        = chk_q;
        chk_phase_d  = chk_phase_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (|bus.req_valid) begin
                    grant_d      = pick;
                    last_grant_d = pick_idx;
`ifdef UART_TX_CHECKSUM_EN
                    chk_d        = CHK_SEED;
`endif
                    state_d      = StLoad;
                end
            end
            StLoad: begin
                // The owner may stall indefinitely; the grant is held meanwhile.
                if (own_valid) begin
                    tx_data_d   = own_data;
                    last_flag_d = own_last;
`ifdef UART_TX_CHECKSUM_EN
                    chk_d       = chk_q ^ own_data;
`endif
                    state_d     = StSend;
                end
            end
            StSend: begin
                state_d = StWait;
            end
            StWait: begin
                if (bus.tx_done) begin
                    if (!last_flag_q) begin
                        state_d = StLoad;
                    end else begin
`ifdef UART_TX_CHECKSUM_EN
                        tx_data_d   = chk_q;
                        chk_phase_d = 2'd0;
                        state_d     = StChk;
`else
                        grant_d     = '0;
                        state_d     = StIdle;
`endif
                    end
                end
            end
`ifdef UART_TX_CHECKSUM_EN
            StChk: begin
                unique case (chk_phase_q)
                    2'd0: chk_phase_d = 2'd1;
                    2'd1: chk_phase_d = 2'd2;
                    default: begin
                        if (bus.tx_done) begin
                            grant_d     = '0;
                            chk_phase_d = 2'd0;
                            state_d     = StIdle;
                        end
                    end
                endcase
            end
`endif
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin : fsm_out
        bus.req_ready = '0;
        bus.tx_start  = 1'b0;
        bus.busy      = (state_q != StIdle);
        bus.tx_data   = tx_data_q;
        bus.grant     = grant_q;
        unique case (state_q)
            StLoad: bus.req_ready = grant_q;
            StSend: bus.tx_start  = 1'b1;
`ifdef UART_TX_CHECKSUM_EN
            StChk:  bus.tx_start  = (chk_phase_q == 2'd1);
`endif
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler with a 10-cycle UART model.
// Expected byte counts adapt to UART_TX_CHECKSUM_EN.
module tb_uart_tx_scheduler;

`ifdef UART_TX_CHECKSUM_EN
    localparam int NB = 3;
`else
    localparam int NB = 2;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic       rv [2];
    logic [7:0] rd [2];
    logic       rl [2];
    logic model_done = 1'b0;
    logic spur_done  = 1'b0;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;
    int stab_viol = 0;
    int onehot_viol = 0;
    int cnt = 0;
    logic holding = 1'b0;
    logic [7:0] hold = '0;
    logic [1:0] prev_grant = '0;

    logic [7:0] tx_log [$];
    logic [1:0] gnt_log [$];
    int start_cyc [$];
    int done_cyc [$];
    int grant_cyc [$];
    logic [7:0] exp_b [$];
    logic [1:0] exp_g [$];

    typedef struct {
        logic       id;
        logic [7:0] b0;
        logic [7:0] b1;
        logic [1:0] exp_grant;
        logic [7:0] exp_chk;
    } vec_t;
    vec_t vecs [4];

    uart_tx_scheduler_if #(.NUM_REQ(2)) bus ();

    assign bus.req_valid = {rv[1], rv[0]};
    assign bus.req_data  = {rd[1], rd[0]};
    assign bus.req_last  = {rl[1], rl[0]};
    assign bus.tx_done   = model_done | spur_done;

    uart_tx_scheduler #(.NUM_REQ(2)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Monitor plus UART model: tx_done 10 cycles after each tx_start.
    always @(negedge clock) begin
        if (!reset) begin
            cnt = 0;
            model_done = 1'b0;
            holding = 1'b0;
            prev_grant = bus.grant;
        end else begin
            if (bus.tx_start) begin
                tx_log.push_back(bus.tx_data);
                gnt_log.push_back(bus.grant);
                start_cyc.push_back(cyc);
                hold = bus.tx_data;
                holding = 1'b1;
            end else if (holding && bus.tx_data !== hold) begin
                stab_viol++;
            end
            if (bus.grant != 2'b00 && prev_grant == 2'b00) grant_cyc.push_back(cyc);
            prev_grant = bus.grant;
            if ($countones(bus.req_ready) > 1) onehot_viol++;
            model_done = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    model_done = 1'b1;
                    done_cyc.push_back(cyc);
                    holding = 1'b0;
                end
            end
            if (bus.tx_start) cnt = 10;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out waiting on DUT", name);
    endtask

    function automatic int qat(input int q [$], input int i);
        return (i < q.size()) ? q[i] : -1000;
    endfunction

    task automatic clear_logs();
        tx_log.delete(); gnt_log.delete(); start_cyc.delete();
        done_cyc.delete(); grant_cyc.delete(); exp_b.delete(); exp_g.delete();
    endtask

    task automatic expect_pkt(input logic [1:0] g, input logic [7:0] b0, input logic [7:0] b1);
        exp_b.push_back(b0);
        exp_b.push_back(b1);
`ifdef UART_TX_CHECKSUM_EN
        exp_b.push_back(b0 ^ b1);
`endif
        for (int i = 0; i < NB; i++) exp_g.push_back(g);
    endtask

    task automatic compare_log(input string tag);
        check({tag, "_count"}, tx_log.size(), exp_b.size());
        for (int i = 0; i < exp_b.size() && i < tx_log.size(); i++) begin
            check($sformatf("%s_byte%0d", tag, i), tx_log[i], exp_b[i]);
            check($sformatf("%s_grant%0d", tag, i), gnt_log[i], exp_g[i]);
        end
    endtask

    // Called at a negedge; returns at the negedge after the byte was accepted.
    task automatic push_byte(input logic id, input logic [7:0] d, input logic last);
        int n;
        n = 0;
        rv[id] = 1'b1;
        rd[id] = d;
        rl[id] = last;
        while (!bus.req_ready[id] && n < 2000) begin
            @(negedge clock);
            n++;
        end
        if (!bus.req_ready[id]) timeout($sformatf("push_req%0d", id));
        @(negedge clock);
        rv[id] = 1'b0;
    endtask

    task automatic send_pkt(input logic id, input logic [7:0] b0, input logic [7:0] b1);
        push_byte(id, b0, 1'b0);
        push_byte(id, b1, 1'b1);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (bus.busy && n < 3000) begin
            @(negedge clock);
            n++;
        end
        if (bus.busy) timeout({tag, "_idle"});
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int ready_cnt;
        int grant_bad;
        int s0;

        vecs[0] = '{id: 1'b0, b0: 8'h41, b1: 8'h42, exp_grant: 2'b01, exp_chk: 8'h03};
        vecs[1] = '{id: 1'b1, b0: 8'h10, b1: 8'h01, exp_grant: 2'b10, exp_chk: 8'h11};
        vecs[2] = '{id: 1'b0, b0: 8'hFF, b1: 8'h0F, exp_grant: 2'b01, exp_chk: 8'hF0};
        vecs[3] = '{id: 1'b1, b0: 8'hA5, b1: 8'h5A, exp_grant: 2'b10, exp_chk: 8'hFF};
        for (int i = 0; i < 2; i++) begin
            rv[i] = 1'b0;
            rd[i] = '0;
            rl[i] = 1'b0;
        end

        // Reset values
        #2 reset = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_grant", bus.grant, 2'b00);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_req_ready", bus.req_ready, 2'b00);
        check("rst_tx_start", bus.tx_start, 1'b0);
        check("rst_tx_data", bus.tx_data, 8'h00);
        reset = 1'b1;
        @(negedge clock);

        // Both valid at cycle 0: requester 0 first, requester 1 two cycles after last done
        clear_logs();
        c0 = cyc;
        fork
            send_pkt(1'b0, 8'h41, 8'h42);
            send_pkt(1'b1, 8'h61, 8'h62);
        join
        wait_idle("both");
        expect_pkt(2'b01, 8'h41, 8'h42);
        expect_pkt(2'b10, 8'h61, 8'h62);
        compare_log("both");
        check("first_grant_latency", qat(grant_cyc, 0) - c0, 1);
        check("first_start_latency", qat(start_cyc, 0) - c0, 2);
        check("byte_to_byte_gap", qat(start_cyc, 1) - qat(done_cyc, 0), 2);
        check("regrant_gap", qat(grant_cyc, 1) - qat(done_cyc, NB - 1), 2);

        // Table of single-requester packets
        for (int i = 0; i < 4; i++) begin
            clear_logs();
            send_pkt(vecs[i].id, vecs[i].b0, vecs[i].b1);
            wait_idle($sformatf("vec%0d", i));
            check($sformatf("vec%0d_count", i), tx_log.size(), NB);
            check($sformatf("vec%0d_b0", i), tx_log.size() > 0 ? tx_log[0] : 8'hxx, vecs[i].b0);
            check($sformatf("vec%0d_b1", i), tx_log.size() > 1 ? tx_log[1] : 8'hxx, vecs[i].b1);
`ifdef UART_TX_CHECKSUM_EN
            check($sformatf("vec%0d_chk", i), tx_log.size() > 2 ? tx_log[2] : 8'hxx,
                  vecs[i].exp_chk);
`endif
            check($sformatf("vec%0d_grant", i), gnt_log.size() > 0 ? gnt_log[0] : 2'bxx,
                  vecs[i].exp_grant);
            check($sformatf("vec%0d_end_grant", i), bus.grant, 2'b00);
        end

        // No interleaving: order 1, 0, 1
        clear_logs();
        fork
            begin
                send_pkt(1'b1, 8'h11, 8'h12);
                send_pkt(1'b1, 8'h31, 8'h32);
            end
            begin
                repeat (3) @(negedge clock);
                send_pkt(1'b0, 8'h21, 8'h22);
            end
        join
        wait_idle("rr");
        expect_pkt(2'b10, 8'h11, 8'h12);
        expect_pkt(2'b01, 8'h21, 8'h22);
        expect_pkt(2'b10, 8'h31, 8'h32);
        compare_log("rr");

        // Owner stalls 50 cycles in LOAD
        clear_logs();
        push_byte(1'b0, 8'h55, 1'b0);
        s0 = 0;
        while (!bus.req_ready[0] && s0 < 100) begin
            @(negedge clock);
            s0++;
        end
        if (!bus.req_ready[0]) timeout("stall_reload");
        s0 = tx_log.size();
        ready_cnt = 0;
        grant_bad = 0;
        repeat (50) begin
            if (bus.req_ready[0]) ready_cnt++;
            if (bus.grant != 2'b01) grant_bad++;
            @(negedge clock);
        end
        check("stall_no_start", tx_log.size(), s0);
        check("stall_ready_held", ready_cnt, 50);
        check("stall_grant_kept", grant_bad, 0);
        c0 = cyc;
        push_byte(1'b0, 8'h66, 1'b1);
        wait_idle("stall");
        check("resume_latency", qat(start_cyc, 1) - c0, 1);
        expect_pkt(2'b01, 8'h55, 8'h66);
        compare_log("stall");

        // Spurious tx_done in IDLE and in LOAD
        clear_logs();
        spur_done = 1'b1;
        @(negedge clock);
        spur_done = 1'b0;
        repeat (3) @(negedge clock);
        check("spur_idle_busy", bus.busy, 1'b0);
        check("spur_idle_starts", tx_log.size(), 0);
        rv[0] = 1'b1;
        rd[0] = 8'h77;
        rl[0] = 1'b1;
        @(negedge clock);
        rv[0] = 1'b0;
        spur_done = 1'b1;
        @(negedge clock);
        spur_done = 1'b0;
        repeat (3) @(negedge clock);
        check("spur_load_busy", bus.busy, 1'b1);
        check("spur_load_ready", bus.req_ready, 2'b01);
        check("spur_load_grant", bus.grant, 2'b01);
        check("spur_load_starts", tx_log.size(), 0);
        push_byte(1'b0, 8'h77, 1'b1);
        wait_idle("spur");
        exp_b.push_back(8'h77);
        exp_g.push_back(2'b01);
`ifdef UART_TX_CHECKSUM_EN
        exp_b.push_back(8'h77);
        exp_g.push_back(2'b01);
`endif
        compare_log("spur");

        // Reset during WAIT of byte 2
        clear_logs();
        send_pkt(1'b0, 8'h81, 8'h82);
        repeat (3) @(negedge clock);
        reset = 1'b0;
        #1;
        check("midrst_busy", bus.busy, 1'b0);
        check("midrst_grant", bus.grant, 2'b00);
        check("midrst_req_ready", bus.req_ready, 2'b00);
        check("midrst_tx_start", bus.tx_start, 1'b0);
        check("midrst_tx_data", bus.tx_data, 8'h00);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        clear_logs();
        c0 = cyc;
        send_pkt(1'b1, 8'h91, 8'h92);
        wait_idle("postrst");
        check("postrst_grant_latency", qat(grant_cyc, 0) - c0, 1);
        expect_pkt(2'b10, 8'h91, 8'h92);
        compare_log("postrst");

        check("tx_data_stable_viol", stab_viol, 0);
        check("req_ready_onehot_viol", onehot_viol, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
